bcd_scan_controller: RTL and testbench
======================================

// Module: bcd_scan_controller
// PURPOSE
//  Time-multiplexes NUM_DIGITS BCD nibbles onto one shared BCD-to-7-segment cathode decoder.
//  Drives the decoder's digit code, ripple-blank and lamp-test inputs, plus active-low digit enables.
//  Provides leading-zero blanking, tear-free frame-synchronous loading and anti-ghost blank gaps.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, legal 2..8
//  PRESCALE      50000  CLK cycles each digit is in its ON phase, >=1
//  BLANK_CYCLES  16     CLK cycles with all digits off before each ON phase, >=1
// PORTS
//  CLK            in   1              system clock, rising edge
//  RST_N          in   1              asynchronous active-low reset
//  DATA_IN        in   4*NUM_DIGITS   nibble k = digit k (digit 0 = least significant, rightmost)
//  LOAD           in   1              capture DATA_IN into pending register this cycle
//  LZB            in   1              1 = enable leading-zero blanking
//  LAMP_TEST      in   1              1 = light every segment of every digit
//  BCD_OUT        out  4              code to decoder IN[3:0]
//  RBI_OUT        out  1              to decoder RBI; 0 blanks the current digit
//  LAMP_TEST_OUT  out  1              to decoder LAMP_TEST
//  DIGIT_EN_N     out  NUM_DIGITS     one-hot-low common-cathode digit enables
//  LOAD_ACK       out  1              1-cycle pulse: pending value became the displayed value
//  FRAME_START    out  1              1-cycle pulse on entering digit 0 ON phase
// BEHAVIOUR
//  Reset (async, immediate): ptr=0, counters=0, state=BLANK, pending/active regs=0, pend flag=0,
//   DIGIT_EN_N=all 1, BCD_OUT=0, RBI_OUT=0, LAMP_TEST_OUT=0, LOAD_ACK=0, FRAME_START=0.
//  FSM: BLANK(BLANK_CYCLES cycles, DIGIT_EN_N all 1) -> ON(PRESCALE cycles, DIGIT_EN_N[ptr]=0) -> BLANK.
//   On ON->BLANK: ptr increments; ptr==NUM_DIGITS-1 wraps to 0 (frame boundary).
//   Frame period = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
//  BCD_OUT, RBI_OUT, LAMP_TEST_OUT register on BLANK entry for the upcoming ptr; stable through ON.
//  Load: LOAD=1 -> pending<=DATA_IN, pend=1; later LOAD before transfer overwrites (last wins).
//   At frame boundary with pend=1: active<=pending, pend=0, LOAD_ACK=1 next cycle.
//   LOAD in the same cycle as transfer: old pending transfers, new value becomes pending, pend stays 1.
//   First frame after reset displays active=0.
//  Blanking: RBI_OUT=0 when LZB=1, ptr>0 and active nibbles ptr..NUM_DIGITS-1 all zero.
//   Digit 0 is never blanked. LAMP_TEST=1 overrides: RBI_OUT=1, LAMP_TEST_OUT=1.
//  Nibbles 10..15 pass unmodified to BCD_OUT; decoder handles them.
//  LZB/LAMP_TEST sampled per digit at BLANK entry; a change takes effect from the next digit.
//  FRAME_START asserts for the first cycle of ptr=0 ON phase.
// CONFIGURATION
//  DIMMING_EN defined: adds input BRIGHT[3:0]. Within ON, 4-bit counter c runs from 0 and wraps;
//   DIGIT_EN_N[ptr]=0 only while c<=BRIGHT, else all 1. BRIGHT=15 = full on. BRIGHT sampled per cycle.
//  DIMMING_EN undefined: no BRIGHT port; digit enabled for the full ON phase.
// TESTING (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2)
//  Reset release, LZB=0 -> DIGIT_EN_N=1111 for 2 cycles, 1110 for 4, BCD_OUT=0, RBI_OUT=1.
//  LOAD 16'h1234 mid-frame -> one LOAD_ACK at boundary; BCD 4,3,2,1 with EN 1110,1101,1011,0111; period 24.
//  LZB=1, 16'h0070 -> RBI_OUT 1,1,0,0 (digits 0..3); 16'h0000 -> only digit 0 shown.
//  LAMP_TEST=1, LZB=1, 16'h0000 -> RBI_OUT=1 and LAMP_TEST_OUT=1 on all 4 digits.
//  LOAD 16'h1111 then 16'h2222 in one frame -> single LOAD_ACK, next frame shows 2,2,2,2.
//  RST_N low during ON of digit 2 -> DIGIT_EN_N=1111 without clock edge; restarts at digit 0, active=0.
//  DIMMING_EN, BRIGHT=1, PRESCALE=4 -> digit enabled 2 of 4 ON cycles; BRIGHT=15 -> 4 of 4.

Source files
------------

// File: rtl/bcd_scan_controller.sv
// Multiplexed BCD display scanner driving a shared BCD-to-7-segment decoder.
// Optional PWM dimming via BRIGHT[3:0] when DIMMING_EN is defined.
module bcd_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [4*NUM_DIGITS-1:0] DATA_IN,
   input  logic                    LOAD,
   input  logic                    LZB,
   input  logic                    LAMP_TEST,
`ifdef DIMMING_EN
   input  logic [3:0]              BRIGHT,
`endif
   output logic [3:0]              BCD_OUT,
   output logic                    RBI_OUT,
   output logic                    LAMP_TEST_OUT,
   output logic [NUM_DIGITS-1:0]   DIGIT_EN_N,
   output logic                    LOAD_ACK,
   output logic                    FRAME_START
);

   localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CNT_W   = ($clog2(CNT_MAX) < 4) ? 4 : $clog2(CNT_MAX);
   localparam int PTR_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_BLANK,
      ST_ON
   } state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [PTR_W-1:0]        ptr, ptr_nxt;

   logic                    seg_load;
   logic                    on_entry;
   logic                    frame_end;

   logic [4*NUM_DIGITS-1:0] pending;
   logic [4*NUM_DIGITS-1:0] active;
   logic                    pend;

   logic [3:0]              cur_nib;
   logic [NUM_DIGITS-1:0]   zero_from;
   logic                    blank_cur;

   // ------------------------------------------------------------------
   // Scan state register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_BLANK;
         cnt   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic and phase events
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      ptr_nxt   = ptr;
      seg_load  = 1'b0;
      on_entry  = 1'b0;
      frame_end = 1'b0;
      case (state)
         ST_BLANK: begin
            // Decoder inputs are captured in the first blank cycle so that a
            // value transferred at the frame boundary is already visible.
            seg_load = (cnt == '0);
            if (cnt == BLANK_LAST) begin
               state_nxt = ST_ON;
               cnt_nxt   = '0;
               on_entry  = 1'b1;
            end
         end
         ST_ON: begin
            if (cnt == ON_LAST) begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
               if (ptr == PTR_LAST) begin
                  ptr_nxt   = '0;
                  frame_end = 1'b1;
               end else begin
                  ptr_nxt = ptr + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            ptr_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Digit enables
   // ------------------------------------------------------------------
   always_comb begin
      DIGIT_EN_N = '1;
      if (state == ST_ON) begin
         for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (PTR_W'(k) == ptr) begin
`ifdef DIMMING_EN
               if (cnt[3:0] <= BRIGHT) begin
                  DIGIT_EN_N[k] = 1'b0;
               end
`else
               DIGIT_EN_N[k] = 1'b0;
`endif
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Current nibble and leading-zero detection on the active value
   // ------------------------------------------------------------------
   always_comb begin
      cur_nib = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (PTR_W'(k) == ptr) begin
            cur_nib = active[4*k +: 4];
         end
      end
   end

   always_comb begin
      zero_from                 = '0;
      zero_from[NUM_DIGITS-1]   = (active[4*(NUM_DIGITS-1) +: 4] == 4'd0);
      for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_from[k-1] = zero_from[k] && (active[4*(k-1) +: 4] == 4'd0);
      end
   end

   always_comb begin
      blank_cur = 1'b0;
      for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
         if (PTR_W'(k) == ptr) begin
            blank_cur = LZB && zero_from[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Load handshake, frame-synchronous transfer and decoder outputs
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending       <= '0;
         active        <= '0;
         pend          <= 1'b0;
         LOAD_ACK      <= 1'b0;
         FRAME_START   <= 1'b0;
         BCD_OUT       <= '0;
         RBI_OUT       <= 1'b0;
         LAMP_TEST_OUT <= 1'b0;
      end else begin
         LOAD_ACK    <= frame_end && pend;
         FRAME_START <= on_entry && (ptr == '0);

         if (frame_end && pend) begin
            active <= pending;
         end

         // A load coinciding with the transfer re-arms pend for the new value.
         if (LOAD) begin
            pending <= DATA_IN;
            pend    <= 1'b1;
         end else if (frame_end) begin
            pend    <= 1'b0;
         end

         if (seg_load) begin
            BCD_OUT       <= cur_nib;
            RBI_OUT       <= LAMP_TEST || !blank_cur;
            LAMP_TEST_OUT <= LAMP_TEST;
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed bench for bcd_scan_controller (4 digits, PRESCALE=4, BLANK_CYCLES=2).
// Frames are 24 cycles; samples are taken on the falling clock edge.
module tb_bcd_scan_controller;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] DATA_IN;
   logic        LOAD;
   logic        LZB;
   logic        LAMP_TEST;
   logic [3:0]  BCD_OUT;
   logic        RBI_OUT;
   logic        LAMP_TEST_OUT;
   logic [3:0]  DIGIT_EN_N;
   logic        LOAD_ACK;
   logic        FRAME_START;
`ifdef DIMMING_EN
   logic [3:0]  bright = 4'hF;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 CLK = ~CLK;

   bcd_scan_controller #(
      .NUM_DIGITS  (4),
      .PRESCALE    (4),
      .BLANK_CYCLES(2)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .DATA_IN      (DATA_IN),
      .LOAD         (LOAD),
      .LZB          (LZB),
      .LAMP_TEST    (LAMP_TEST),
`ifdef DIMMING_EN
      .BRIGHT       (bright),
`endif
      .BCD_OUT      (BCD_OUT),
      .RBI_OUT      (RBI_OUT),
      .LAMP_TEST_OUT(LAMP_TEST_OUT),
      .DIGIT_EN_N   (DIGIT_EN_N),
      .LOAD_ACK     (LOAD_ACK),
      .FRAME_START  (FRAME_START)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts on the sample of a frame's first blank cycle and ends on the next one.
   // ld*_at: frame cycle index at which LOAD is driven high (-1 = none).
   task automatic run_frame(input logic [15:0] exp_bcd, input logic [3:0] exp_rbi,
                            input logic exp_lt, input logic exp_ack,
                            input int ld1_at, input logic [15:0] ld1,
                            input int ld2_at, input logic [15:0] ld2);
      int idx;
      logic [3:0] en_exp;
      idx = 0;
      for (int d = 0; d < 4; d++) begin
         for (int j = 0; j < 6; j++) begin
            en_exp = 4'hF;
            if (j >= 2) begin
               en_exp = ~(4'b0001 << d);
`ifdef DIMMING_EN
               if ((j - 2) > int'(bright)) en_exp = 4'hF;
`endif
            end
            chk("digit_en_n", 16'(DIGIT_EN_N), 16'(en_exp));
            chk("load_ack", 16'(LOAD_ACK), 16'((idx == 0) && exp_ack));
            chk("frame_start", 16'(FRAME_START), 16'((d == 0) && (j == 2)));
            if (j >= 2) begin
               chk("bcd_out", 16'(BCD_OUT), 16'(exp_bcd[4*d +: 4]));
               chk("rbi_out", 16'(RBI_OUT), 16'(exp_rbi[d]));
               chk("lamp_test_out", 16'(LAMP_TEST_OUT), 16'(exp_lt));
            end
            if (idx == ld1_at) begin
               DATA_IN = ld1;
               LOAD    = 1'b1;
            end else if (idx == ld2_at) begin
               DATA_IN = ld2;
               LOAD    = 1'b1;
            end else begin
               LOAD    = 1'b0;
            end
            @(negedge CLK);
            idx++;
         end
      end
      LOAD = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RST_N     = 1'b0;
      DATA_IN   = '0;
      LOAD      = 1'b0;
      LZB       = 1'b0;
      LAMP_TEST = 1'b0;
      repeat (2) @(negedge CLK);

      chk("rst_digit_en_n", 16'(DIGIT_EN_N), 16'h000F);
      chk("rst_bcd_out", 16'(BCD_OUT), 16'h0000);
      chk("rst_rbi_out", 16'(RBI_OUT), 16'h0000);
      chk("rst_lamp_test_out", 16'(LAMP_TEST_OUT), 16'h0000);
      chk("rst_load_ack", 16'(LOAD_ACK), 16'h0000);
      chk("rst_frame_start", 16'(FRAME_START), 16'h0000);

      RST_N = 1'b1;
      // First frame shows zeros; 1234 loaded mid-frame.
      run_frame(16'h0000, 4'b1111, 1'b0, 1'b0, 10, 16'h1234, -1, 16'h0000);
      run_frame(16'h1234, 4'b1111, 1'b0, 1'b1, 10, 16'h0070, -1, 16'h0000);
      LZB = 1'b1;
      run_frame(16'h0070, 4'b0011, 1'b0, 1'b1, 10, 16'h0000, -1, 16'h0000);
      run_frame(16'h0000, 4'b0001, 1'b0, 1'b1, -1, 16'h0000, -1, 16'h0000);
      LAMP_TEST = 1'b1;
      // Two loads in one frame: last one wins, single ack.
      run_frame(16'h0000, 4'b1111, 1'b1, 1'b0, 3, 16'h1111, 15, 16'h2222);
      LAMP_TEST = 1'b0;
      // Second load lands on the frame boundary cycle.
      run_frame(16'h2222, 4'b1111, 1'b0, 1'b1, 5, 16'h5A09, 23, 16'h0F00);
      run_frame(16'h5A09, 4'b1111, 1'b0, 1'b1, -1, 16'h0000, -1, 16'h0000);
      run_frame(16'h0F00, 4'b0111, 1'b0, 1'b1, -1, 16'h0000, -1, 16'h0000);
      run_frame(16'h0F00, 4'b0111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000);

      // Asynchronous reset during digit 2 ON phase.
      repeat (14) @(negedge CLK);
      chk("pre_reset_digit_en_n", 16'(DIGIT_EN_N), 16'h000B);
      #2 RST_N = 1'b0;
      #1;
      chk("async_rst_digit_en_n", 16'(DIGIT_EN_N), 16'h000F);
      chk("async_rst_bcd_out", 16'(BCD_OUT), 16'h0000);
      chk("async_rst_rbi_out", 16'(RBI_OUT), 16'h0000);
      chk("async_rst_load_ack", 16'(LOAD_ACK), 16'h0000);
      chk("async_rst_frame_start", 16'(FRAME_START), 16'h0000);
      @(negedge CLK);
      LZB   = 1'b0;
      RST_N = 1'b1;
      run_frame(16'h0000, 4'b1111, 1'b0, 1'b0, 2, 16'h8765, -1, 16'h0000);
      run_frame(16'h8765, 4'b1111, 1'b0, 1'b1, -1, 16'h0000, -1, 16'h0000);

`ifdef DIMMING_EN
      bright = 4'd1;
      run_frame(16'h8765, 4'b1111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000);
      bright = 4'd15;
      run_frame(16'h8765, 4'b1111, 1'b0, 1'b0, -1, 16'h0000, -1, 16'h0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
